// File: rtl/id_inst_buffer_if.sv
// IF -> ID instruction buffer bus: push side from IF, pop side to ID, plus status.
interface id_inst_buffer_if #(
    parameter int DEPTH  = 4,
    parameter int PC_W   = 32,
    parameter int INST_W = 32
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic              flush;
    logic              if_valid;
    logic [PC_W-1:0]   if_pc;
    logic [INST_W-1:0] if_inst;
    logic              if_ready;
    logic              afull;
    logic              id_valid;
    logic [PC_W-1:0]   id_pc;
    logic [INST_W-1:0] id_inst;
    logic              id_ready;
    logic [CW-1:0]     count;
    logic              overflow_err;

    // Pipeline side (IF, ID and the stall/flush controller).
    modport master (
        output flush, if_valid, if_pc, if_inst, id_ready,
        input  if_ready, afull, id_valid, id_pc, id_inst, count, overflow_err
    );

    // Buffer side.
    modport slave (
        input  flush, if_valid, if_pc, if_inst, id_ready,
        output if_ready, afull, id_valid, id_pc, id_inst, count, overflow_err
    );
endinterface

// File: rtl/id_inst_buffer.sv
// Circular {pc, inst} FIFO between IF and ID with optional empty-buffer bypass
// and single-cycle flush.
module id_inst_buffer #(
    parameter int DEPTH    = 4,
    parameter int PC_W     = 32,
    parameter int INST_W   = 32,
    parameter int BYPASS   = 1,
    parameter int AFULL_TH = 3
) (
    input  logic            clk,
    input  logic            rst,
    id_inst_buffer_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_CNT = CW'(AFULL_TH);

    logic [PC_W-1:0]   mem_pc   [DEPTH];
    logic [INST_W-1:0] mem_inst [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CW-1:0]     cnt;
    logic              ovf;

    logic              empty;
    logic              ready;
    logic              push;
    logic              pop;
    logic              wr_en;
    logic              rd_en;
    logic              valid_c;
    logic [PC_W-1:0]   pc_c;
    logic [INST_W-1:0] inst_c;

    assign empty = (cnt == '0);
    assign ready = (cnt != FULL_CNT);

    // Present the stored head, or the live fetch when empty and bypass is enabled.
    always_comb begin
        valid_c = 1'b0;
        pc_c    = '0;
        inst_c  = '0;
        if (!empty) begin
            valid_c = 1'b1;
            pc_c    = mem_pc[rd_ptr];
            inst_c  = mem_inst[rd_ptr];
        end else if (BYPASS != 0) begin
            valid_c = bus.if_valid & ~bus.flush;
            pc_c    = bus.if_pc;
            inst_c  = bus.if_inst;
        end
    end

    assign push = bus.if_valid & ready & ~bus.flush;
    assign pop  = valid_c & bus.id_ready & ~bus.flush;

    // A bypassed instruction consumed in the same cycle never touches storage.
    assign wr_en = push & ~(empty & pop);
    assign rd_en = pop & ~empty;

    // Storage array: data only, no reset needed.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_pc[wr_ptr]   <= bus.if_pc;
            mem_inst[wr_ptr] <= bus.if_inst;
        end
    end

    // Pointers and occupancy; flush outranks push and pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (bus.flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PW'(1);
            if (rd_en) rd_ptr <= rd_ptr + PW'(1);
            if (wr_en && !rd_en)
                cnt <= cnt + CW'(1);
            else if (rd_en && !wr_en)
                cnt <= cnt - CW'(1);
        end
    end

    // Sticky flag for IF pushing into a full buffer outside a flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ovf <= 1'b0;
        else if (bus.if_valid && !ready && !bus.flush)
            ovf <= 1'b1;
    end

    assign bus.if_ready     = ready;
    assign bus.afull        = (cnt >= AFULL_CNT);
    assign bus.id_valid     = valid_c;
    assign bus.id_pc        = pc_c;
    assign bus.id_inst      = inst_c;
    assign bus.count        = cnt;
    assign bus.overflow_err = ovf;
endmodule

// File: tb/tb_id_inst_buffer.sv
// Drives a bypass and a non-bypass buffer with identical stimulus and checks
// both against queue-based reference models every cycle.
module tb_id_inst_buffer;
    localparam int DEPTH    = 4;
    localparam int PC_W     = 32;
    localparam int INST_W   = 32;
    localparam int AFULL_TH = 3;

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [INST_W-1:0] inst;
    } pair_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    id_inst_buffer_if #(.DEPTH(DEPTH), .PC_W(PC_W), .INST_W(INST_W)) bus_b ();
    id_inst_buffer_if #(.DEPTH(DEPTH), .PC_W(PC_W), .INST_W(INST_W)) bus_n ();

    id_inst_buffer #(.DEPTH(DEPTH), .PC_W(PC_W), .INST_W(INST_W), .BYPASS(1), .AFULL_TH(AFULL_TH))
        dut_b (.clk(clk), .rst(rst), .bus(bus_b));
    id_inst_buffer #(.DEPTH(DEPTH), .PC_W(PC_W), .INST_W(INST_W), .BYPASS(0), .AFULL_TH(AFULL_TH))
        dut_n (.clk(clk), .rst(rst), .bus(bus_n));

    int n_tests = 0;
    int n_fail  = 0;

    pair_t qb[$];
    pair_t qn[$];
    bit    ovf_b = 1'b0;
    bit    ovf_n = 1'b0;

    logic              cur_vld = 1'b0;
    logic [PC_W-1:0]   cur_pc  = '0;
    logic [INST_W-1:0] cur_inst = '0;
    logic              cur_rdy = 1'b0;
    logic              cur_fl  = 1'b0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic drive(input logic vld, input logic [PC_W-1:0] pc,
                         input logic [INST_W-1:0] inst, input logic rdy, input logic fl);
        cur_vld = vld; cur_pc = pc; cur_inst = inst; cur_rdy = rdy; cur_fl = fl;
        bus_b.if_valid = vld; bus_b.if_pc = pc; bus_b.if_inst = inst;
        bus_b.id_ready = rdy; bus_b.flush = fl;
        bus_n.if_valid = vld; bus_n.if_pc = pc; bus_n.if_inst = inst;
        bus_n.id_ready = rdy; bus_n.flush = fl;
    endtask

    task automatic check_all();
        int    sb;
        int    sn;
        pair_t hb;
        pair_t hn;
        logic  vb;
        sb = qb.size();
        sn = qn.size();
        hb = (sb > 0) ? qb[0] : '0;
        hn = (sn > 0) ? qn[0] : '0;
        vb = (sb > 0) ? 1'b1 : (cur_vld & ~cur_fl);
        chk("b.id_valid", 64'(bus_b.id_valid), 64'(vb));
        chk("b.id_pc",    64'(bus_b.id_pc),    64'((sb > 0) ? hb.pc   : cur_pc));
        chk("b.id_inst",  64'(bus_b.id_inst),  64'((sb > 0) ? hb.inst : cur_inst));
        chk("b.if_ready", 64'(bus_b.if_ready), 64'(sb != DEPTH));
        chk("b.afull",    64'(bus_b.afull),    64'(sb >= AFULL_TH));
        chk("b.count",    64'(bus_b.count),    64'(sb));
        chk("b.ovf",      64'(bus_b.overflow_err), 64'(ovf_b));
        chk("n.id_valid", 64'(bus_n.id_valid), 64'(sn > 0));
        chk("n.id_pc",    64'(bus_n.id_pc),    64'(hn.pc));
        chk("n.id_inst",  64'(bus_n.id_inst),  64'(hn.inst));
        chk("n.if_ready", 64'(bus_n.if_ready), 64'(sn != DEPTH));
        chk("n.afull",    64'(bus_n.afull),    64'(sn >= AFULL_TH));
        chk("n.count",    64'(bus_n.count),    64'(sn));
        chk("n.ovf",      64'(bus_n.overflow_err), 64'(ovf_n));
    endtask

    // Advance both reference models across the coming clock edge.
    task automatic model_update();
        int   sb;
        int   sn;
        logic vb;
        logic pop_b;
        logic pop_n;
        sb = qb.size();
        sn = qn.size();
        vb = (sb > 0) ? 1'b1 : (cur_vld & ~cur_fl);
        if (cur_vld && sb == DEPTH && !cur_fl) ovf_b = 1'b1;
        if (cur_vld && sn == DEPTH && !cur_fl) ovf_n = 1'b1;
        if (cur_fl) begin
            qb.delete();
            qn.delete();
        end else begin
            pop_b = vb & cur_rdy;
            if (pop_b && sb > 0) void'(qb.pop_front());
            if (cur_vld && sb != DEPTH && !(pop_b && sb == 0))
                qb.push_back({cur_pc, cur_inst});
            pop_n = (sn > 0) & cur_rdy;
            if (pop_n) void'(qn.pop_front());
            if (cur_vld && sn != DEPTH)
                qn.push_back({cur_pc, cur_inst});
        end
    endtask

    task automatic cycle(input logic vld, input logic [PC_W-1:0] pc,
                         input logic [INST_W-1:0] inst, input logic rdy, input logic fl);
        @(negedge clk);
        drive(vld, pc, inst, rdy, fl);
        #1;
        check_all();
        model_update();
    endtask

    task automatic reset_check(input string tag);
        chk({tag, ".b.id_valid"}, 64'(bus_b.id_valid), 64'(0));
        chk({tag, ".b.count"},    64'(bus_b.count), 64'(0));
        chk({tag, ".b.if_ready"}, 64'(bus_b.if_ready), 64'(1));
        chk({tag, ".b.afull"},    64'(bus_b.afull), 64'(0));
        chk({tag, ".b.ovf"},      64'(bus_b.overflow_err), 64'(0));
        chk({tag, ".b.id_pc"},    64'(bus_b.id_pc), 64'(0));
        chk({tag, ".n.id_valid"}, 64'(bus_n.id_valid), 64'(0));
        chk({tag, ".n.count"},    64'(bus_n.count), 64'(0));
        chk({tag, ".n.if_ready"}, 64'(bus_n.if_ready), 64'(1));
        chk({tag, ".n.ovf"},      64'(bus_n.overflow_err), 64'(0));
        chk({tag, ".n.id_inst"},  64'(bus_n.id_inst), 64'(0));
    endtask

    initial begin
        logic [PC_W-1:0] pc;
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        #1;
        reset_check("rst0");
        @(negedge clk);
        rst = 1'b0;

        // Bypass with ID ready: same-cycle presentation, nothing stored in the bypass buffer.
        cycle(1'b1, 32'hBFC0_0000, 32'h3C01_1234, 1'b1, 1'b0);
        cycle(1'b0, '0, '0, 1'b1, 1'b0);

        // Fill with ID stalled, overflow on the fifth push, then drain in order.
        for (int i = 0; i < 4; i++)
            cycle(1'b1, 32'h100 + 32'(4 * i), 32'hA000_0000 + 32'(i), 1'b0, 1'b0);
        cycle(1'b1, 32'h110, 32'hDEAD_BEEF, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++)
            cycle(1'b0, '0, '0, 1'b1, 1'b0);

        // Steady push and pop at occupancy 2, crossing pointer wrap.
        cycle(1'b1, 32'h300, 32'h1, 1'b0, 1'b0);
        cycle(1'b1, 32'h304, 32'h2, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++)
            cycle(1'b1, 32'h308 + 32'(4 * i), 32'h10 + 32'(i), 1'b1, 1'b0);

        // Grow to 3, then flush while IF pushes.
        cycle(1'b1, 32'h400, 32'h40, 1'b0, 1'b0);
        cycle(1'b1, 32'h404, 32'h41, 1'b1, 1'b1);
        cycle(1'b0, '0, '0, 1'b0, 1'b0);

        // Push into an empty buffer with ID ready: shows the 1-cycle latency without bypass.
        cycle(1'b1, 32'h200, 32'h2000, 1'b1, 1'b0);
        cycle(1'b0, '0, '0, 1'b1, 1'b0);
        cycle(1'b0, '0, '0, 1'b1, 1'b0);

        // Asynchronous reset between edges with data held and the overflow flag set.
        for (int i = 0; i < 5; i++)
            cycle(1'b1, 32'h500 + 32'(4 * i), 32'h50 + 32'(i), 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        reset_check("rst_mid");
        qb.delete();
        qn.delete();
        ovf_b = 1'b0;
        ovf_n = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // Random traffic.
        pc = 32'h1000;
        for (int i = 0; i < 400; i++) begin
            logic vld;
            logic rdy;
            logic fl;
            vld = ($urandom_range(0, 9) < 7);
            rdy = ($urandom_range(0, 9) < 5);
            fl  = ($urandom_range(0, 99) < 6);
            cycle(vld, pc, $urandom, rdy, fl);
            if (vld) pc = pc + 32'd4;
        end

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/id_inst_buffer.md
Name: id_inst_buffer

Overview:
- Parametrised instruction buffer between IF and ID. It holds {pc, inst} pairs in a circular FIFO.
- An IF→ID stall no longer drops or zeroes the fetched instruction, so the old "bubble on stall" register can be retired.
- ID pulls entries with a valid/ready handshake. A taken branch or exception flushes the buffer in one cycle.
- Optional same-cycle bypass when the buffer is empty keeps the no-stall path at zero added latency.

Parameters:
- DEPTH, 4: number of entries; power of two, at least 2.
- PC_W, 32: PC width.
- INST_W, 32: instruction width.
- BYPASS, 1: 1 enables the empty-buffer pass-through; 0 gives 1-cycle minimum latency.
- AFULL_TH, 3: occupancy at or above which afull asserts; legal range 1..DEPTH.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  discard all entries and reject this cycle's push.
- if_valid  in  1  IF presents a fetched instruction.
- if_pc  in  PC_W  PC of the fetched instruction.
- if_inst  in  INST_W  fetched instruction word (already aligned to if_pc).
- if_ready  out  1  buffer accepts a push this cycle.
- afull  out  1  count >= AFULL_TH; IF uses it to throttle early.
- id_valid  out  1  head entry (or bypassed instruction) is valid.
- id_pc  out  PC_W  PC presented to ID.
- id_inst  out  INST_W  instruction presented to ID.
- id_ready  in  1  ID consumes the presented instruction this cycle.
- count  out  $clog2(DEPTH)+1  current occupancy.
- overflow_err  out  1  sticky; IF drove if_valid while if_ready=0 and flush=0.

Behaviour:
- Reset (async, rst=1): wr_ptr=0, rd_ptr=0, count=0, overflow_err=0. Outputs then read if_ready=1, afull=0, id_valid=0, id_pc=0, id_inst=0. Storage array contents are don't-care.
- if_ready = (count != DEPTH). It depends only on registered state: no combinational path from id_ready, and no push when full even if a pop happens the same cycle.
- push = if_valid & if_ready & ~flush.
- pop = id_valid & id_ready & ~flush.
- Normal output: when count > 0, the head entry mem[rd_ptr] drives id_pc/id_inst and id_valid=1.
- Bypass, BYPASS=1 and count==0:
  - id_valid = if_valid & ~flush; id_pc/id_inst = if_pc/if_inst.
  - If id_ready=1, the instruction is consumed directly and not written (count stays 0).
  - If id_ready=0, it is written like a normal push.
- BYPASS=0 and count==0: id_valid=0 and id_pc/id_inst=0. Minimum push-to-present latency is 1 cycle.
- Unchanged stored state: id_pc/id_inst hold while id_valid=1 and id_ready=0.
- Pointers: increment modulo DEPTH by natural wrap (DEPTH is a power of two).
- count update: +1 on push only, -1 on pop only, unchanged on push&pop (count never exceeds DEPTH).
- Flush (synchronous, highest priority):
  - Next edge: wr_ptr=rd_ptr=0, count=0.
  - In the flush cycle, id_valid=0 in bypass mode; a stored head may still show id_valid=1 but is not popped.
  - No push that cycle.
  - Branch delay-slot retention is IF's responsibility: IF re-presents the slot after flush if needed.
- overflow_err: set on the edge where if_valid & ~if_ready & ~flush; cleared only by rst.
- Reset mid-operation: all state clears immediately, without waiting for clk; in-flight data is lost.
- afull is registered-state combinational: count >= AFULL_TH.
- stall-vector integration: the CPU stall controller drives id_ready = (stall[2]==NoStop). IF uses ~if_ready | afull as stallreq.

Test Plan:
- Reset with rst=1 asserted mid-cycle → outputs clear without a clock edge: id_valid=0, count=0, if_ready=1, overflow_err=0.
- BYPASS=1, empty, if_valid=1, if_pc=0xBFC00000, if_inst=0x3C011234, id_ready=1 → same cycle id_valid=1 with those values; count stays 0.
- id_ready=0, push 4 instructions at pc 0x100,0x104,0x108,0x10C → count=4, if_ready=0, afull=1 from count=3. Fifth if_valid → not stored, overflow_err=1. Release id_ready → pops in order 0x100..0x10C.
- Steady push&pop at count=2 over 10 cycles, crossing wr_ptr/rd_ptr wrap → count stays 2, PCs emerge strictly in order, none lost or duplicated.
- count=3, flush=1 with if_valid=1 → next cycle count=0, id_valid=0, the flushing-cycle instruction is discarded, overflow_err unchanged.
- BYPASS=0, empty, push pc 0x200 → id_valid=0 in the push cycle and id_valid=1 with id_pc=0x200 the following cycle.
